spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master moving one 96-bit frame per start.
// Sends {addr, wdata, 32'h0} and returns words two and three.
module spi_master #(
  parameter int CLK_DIV = 100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] rstat,
  output logic        spi_sck,
  output logic        spi_ss_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  localparam logic [6:0] LAST_BIT = 7'd96;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] hcnt;
  logic [6:0]    bit_cnt;
  logic [94:0]   tx_sr;
  logic [63:0]   rx_sr;
  logic          tick;

  // A half-period boundary is reached when the phase counter hits zero.
  assign tick = (hcnt == '0);

  // Frame sequencer: drives SCK/SS/MOSI, shifts data, reports completion.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rdata    <= '0;
      rstat    <= '0;
      spi_sck  <= 1'b0;
      spi_ss_n <= 1'b1;
      spi_mosi <= 1'b0;
      hcnt     <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            spi_ss_n <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= addr[31];
            tx_sr    <= {addr[30:0], wdata, 32'h0};
            hcnt     <= RELOAD;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (!tick) begin
            hcnt <= hcnt - 1'b1;
          end else begin
            hcnt <= RELOAD;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[62:0], spi_miso};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
              spi_sck  <= 1'b0;
              spi_mosi <= 1'b0;
              state    <= HOLD;
            end else begin
              spi_sck  <= 1'b0;
              spi_mosi <= tx_sr[94];
              tx_sr    <= {tx_sr[93:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (!tick) begin
            hcnt <= hcnt - 1'b1;
          end else begin
            hcnt     <= RELOAD;
            spi_ss_n <= 1'b1;
            state    <= GAP;
          end
        end
        GAP: begin
          if (!tick) begin
            hcnt <= hcnt - 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            rdata <= rx_sr[63:32];
            rstat <= rx_sr[31:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master framing and timing.
// Slave model drives a 96-bit vector, mode 0, MSB first.
module tb_spi_master;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [31:0] rstat;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .rstat    (rstat),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [95:0] vec  = '0;
  int          mode = 0;
  int          idx  = 0;

  // slave: bit idx is presented until the next SCK fall
  always_comb begin
    spi_miso = 1'b0;
    if (mode == 1)
      spi_miso = 1'b1;
    else if (mode == 0 && idx < 96)
      spi_miso = vec[95-idx];
  end

  logic [95:0] mosi_cap = '0;
  int   rises    = 0;
  int   frames   = 0;
  int   done_cnt = 0;
  int   run      = 0;
  int   last_run = 0;
  int   t_fall   = 0;
  int   t_rise1  = 0;
  int   t_ssrise = 0;
  int   t_done   = 0;
  logic sck_p    = 1'b0;
  logic ss_p     = 1'b1;

  // bus monitor sampled mid-cycle
  always @(negedge clk) begin
    if (spi_ss_n === 1'b0 && ss_p === 1'b1) begin
      t_fall   = cyc;
      frames++;
      rises    = 0;
      mosi_cap = '0;
      idx      = 0;
      last_run = run;
    end
    if (spi_ss_n === 1'b1 && ss_p === 1'b0)
      t_ssrise = cyc;
    run = (spi_ss_n === 1'b1) ? run + 1 : 0;
    if (spi_sck === 1'b1 && sck_p === 1'b0) begin
      if (rises == 0) t_rise1 = cyc;
      rises++;
      mosi_cap = {mosi_cap[94:0], spi_mosi};
    end
    if (spi_sck === 1'b0 && sck_p === 1'b1)
      idx++;
    if (done === 1'b1) begin
      done_cnt++;
      t_done = cyc;
    end
    sck_p = spi_sck;
    ss_p  = spi_ss_n;
  end

  int t0 = 0;

  task automatic do_start(input logic [31:0] a,
                          input logic [31:0] w);
    addr  = a;
    wdata = w;
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 96'(done), 96'(1));
  endtask

  initial begin
    int d0;
    int f0;
    int r;
    int n;
    logic p;

    rstn  = 1'b0;
    start = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    addr  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_ss_n",  96'(spi_ss_n), 96'(1));
    check("rst_busy",  96'(busy),     96'(0));
    check("rst_done",  96'(done),     96'(0));
    check("rst_rdata", 96'(rdata),    96'(0));
    check("rst_rstat", 96'(rstat),    96'(0));
    check("rst_sck",   96'(spi_sck),  96'(0));
    check("rst_mosi",  96'(spi_mosi), 96'(0));
    start = 1'b0;
    addr  = 32'h0;
    rstn  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idle_ss_n", 96'(spi_ss_n), 96'(1));

    vec = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001};
    d0  = done_cnt;
    do_start(32'h0000_0004, 32'h0);
    check("a_busy1", 96'(busy),     96'(1));
    check("a_ss_n1", 96'(spi_ss_n), 96'(0));
    check("a_mosi1", 96'(spi_mosi), 96'(0));
    wait_done("a_done");
    check("a_busy_done", 96'(busy), 96'(0));
    repeat (2) @(negedge clk);
    check("a_rdata", 96'(rdata), 96'(32'hDEAD_BEEF));
    check("a_rstat", 96'(rstat), 96'(32'h0000_0001));
    check("a_mosi",  mosi_cap,
          {32'h0000_0004, 32'h0, 32'h0});
    check("a_rises", 96'(rises), 96'(96));
    check("a_ndone", 96'(done_cnt - d0), 96'(1));
    check("a_t_ssfall", 96'(t_fall - t0),   96'(1));
    check("a_t_rise1",  96'(t_rise1 - t0),  96'(5));
    check("a_t_ssrise", 96'(t_ssrise - t0), 96'(773));
    check("a_t_done",   96'(t_done - t0),   96'(777));

    vec = {32'h0F0F_0F0F, 32'h8421_8421, 32'h7E7E_0000};
    d0  = done_cnt;
    f0  = frames;
    do_start(32'h1111_2222, 32'h3333_4444);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1;
    addr  = 32'hFFFF_FFFF;
    wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 400) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    wait_done("b_done");
    repeat (20) @(negedge clk);
    check("b_mosi", mosi_cap,
          {32'h1111_2222, 32'h3333_4444, 32'h0});
    check("b_frames", 96'(frames - f0),   96'(1));
    check("b_ndone",  96'(done_cnt - d0), 96'(1));
    check("b_ss_n",   96'(spi_ss_n),      96'(1));
    check("b_rdata",  96'(rdata), 96'(32'h8421_8421));

    vec = {32'hCAFE_0000, 32'h0BAD_F00D, 32'h0000_00A1};
    do_start(32'h0000_0004, 32'h0);
    wait_done("c_done1");
    check("c_rdata1", 96'(rdata), 96'(32'h0BAD_F00D));
    vec = {32'h0, 32'h1357_9BDF, 32'h2468_ACE0};
    do_start(32'hA5A5_0008, 32'h5A5A_0000);
    check("c_mosi1", 96'(spi_mosi), 96'(1));
    check("c_ss_n1", 96'(spi_ss_n), 96'(0));
    repeat (300) @(negedge clk);
    check("c_rdata_hold", 96'(rdata), 96'(32'h0BAD_F00D));
    check("c_rstat_hold", 96'(rstat), 96'(32'h0000_00A1));
    check("c_busy_mid",   96'(busy),  96'(1));
    wait_done("c_done2");
    repeat (2) @(negedge clk);
    check("c_rdata2", 96'(rdata), 96'(32'h1357_9BDF));
    check("c_rstat2", 96'(rstat), 96'(32'h2468_ACE0));
    check("c_gap",    96'(last_run), 96'(5));
    check("c_mosi",   mosi_cap,
          {32'hA5A5_0008, 32'h5A5A_0000, 32'h0});
    check("c_t_done", 96'(t_done - t0), 96'(777));

    vec = {32'hFFFF_0000, 32'h5555_AAAA, 32'h3C3C_C3C3};
    do_start(32'h8000_0001, 32'h1);
    r = 0;
    n = 0;
    p = spi_sck;
    while (r < 40 && n < 2000) begin
      @(negedge clk);
      n++;
      if (spi_sck && !p) r++;
      p = spi_sck;
    end
    check("d_40rises", 96'(r), 96'(40));
    d0   = done_cnt;
    f0   = frames;
    rstn = 1'b0;
    @(negedge clk);
    check("d_ss_n",  96'(spi_ss_n), 96'(1));
    check("d_sck",   96'(spi_sck),  96'(0));
    check("d_busy",  96'(busy),     96'(0));
    check("d_mosi",  96'(spi_mosi), 96'(0));
    check("d_rdata", 96'(rdata),    96'(0));
    check("d_rstat", 96'(rstat),    96'(0));
    rstn = 1'b1;
    repeat (900) @(negedge clk);
    check("d_no_done",   96'(done_cnt - d0), 96'(0));
    check("d_no_frame",  96'(frames - f0),   96'(0));
    check("d_rdata_end", 96'(rdata),         96'(0));

    mode = 1;
    do_start(32'h0000_0004, 32'h0);
    wait_done("e_done1");
    @(negedge clk);
    check("e_rdata1", 96'(rdata), 96'(32'hFFFF_FFFF));
    check("e_rstat1", 96'(rstat), 96'(32'hFFFF_FFFF));
    mode = 2;
    do_start(32'h0000_0004, 32'h0);
    wait_done("e_done0");
    @(negedge clk);
    check("e_rdata0", 96'(rdata), 96'(0));
    check("e_rstat0", 96'(rstat), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
